// File: rtl/mem_ctrl_lat.sv
// Single-port word memory behind a fixed-latency valid/ready controller.
// One transaction in flight; byte-strobed writes; out-of-range accesses report resp_err.
module mem_ctrl_lat_lane #(
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module mem_ctrl_lat #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 24,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                busy
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int CW        = $clog2(LATENCY + 1);
  localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                         we;
    logic [ADDR_W-1:0]            addr;
    logic [NUM_LANES-1:0][7:0]    wdata;
    logic [NUM_LANES-1:0]         wstrb;
  } req_t;

  state_t                    state_q, state_d;
  req_t                      req_q;
  logic [CW-1:0]             cnt_q;
  logic                      in_range, commit;
  logic [NUM_LANES-1:0][7:0] rd_lane;

  // Full-width compare with one spare bit so DEPTH == 2**ADDR_W still fits.
  assign in_range  = {1'b0, req_q.addr} < (ADDR_W+1)'(DEPTH);
  assign commit    = (state_q == WAIT) && (cnt_q == '0);
  assign req_ready = (state_q == IDLE);
  assign busy      = !req_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)  state_d = WAIT;
      WAIT:    if (commit)     state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= '0;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
          cnt_q <= CW'(LATENCY - 1);
        end
        WAIT: if (commit) begin
          resp_valid <= 1'b1;
          resp_err   <= !in_range;
          resp_rdata <= (req_q.we || !in_range) ? '0 : rd_lane;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  // Reset on the commit edge must also suppress the write.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_ctrl_lat_lane #(.DEPTH(DEPTH), .IW(IW)) u_lane (
      .clk   (clk),
      .we    (commit && req_q.we && in_range && req_q.wstrb[i] && !rst),
      .idx   (req_q.addr[IW-1:0]),
      .wdata (req_q.wdata[i]),
      .rdata (rd_lane[i])
    );
  end
endmodule

// File: tb/tb_mem_ctrl_lat.sv
// Directed bench for mem_ctrl_lat: three instances (LATENCY 4, 1, 7) share
// request payload inputs; each has its own valid/ready handshake signals.
module tb_mem_ctrl_lat;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid, resp_ready;
  logic [2:0]  req_ready, resp_valid, resp_err, busy;
  logic        req_we;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] resp_rdata [3];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_ctrl_lat #(.DATA_W(32), .ADDR_W(24), .DEPTH(256), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .busy(busy[0]));

  mem_ctrl_lat #(.DATA_W(32), .ADDR_W(24), .DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .busy(busy[1]));

  mem_ctrl_lat #(.DATA_W(32), .ADDR_W(24), .DEPTH(256), .LATENCY(7)) u_l7 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]), .busy(busy[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 7);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int k);
    int cyc = 0;
    while (!req_ready[k] && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 20) check("req_ready_timeout", 32'(req_ready[k]), 32'd1);
  endtask

  // One full transaction; 'hold' cycles of back-pressure with a competing request driven.
  task automatic txn(input int k, input logic we, input logic [23:0] addr,
                     input logic [31:0] wd, input logic [3:0] ws,
                     input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int cyc;
    wait_ready(k);
    req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws; req_valid[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    check("busy_after_accept", 32'(busy[k]), 32'd1);
    cyc = 0;
    while (!resp_valid[k] && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("latency", 32'(cyc), 32'(lat_of(k)));
    check("rdata", resp_rdata[k], exp_rd);
    check("err", 32'(resp_err[k]), 32'(exp_err));
    if (hold > 0) begin
      req_we = 1'b1; req_addr = 24'd4; req_wdata = 32'h0; req_wstrb = 4'hF; req_valid[k] = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        check("bp_valid", 32'(resp_valid[k]), 32'd1);
        check("bp_rdata", resp_rdata[k], exp_rd);
        check("bp_err", 32'(resp_err[k]), 32'(exp_err));
        check("bp_req_ready", 32'(req_ready[k]), 32'd0);
      end
      req_valid[k] = 1'b0;
    end
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
    check("post_valid", 32'(resp_valid[k]), 32'd0);
    check("post_rdata", resp_rdata[k], 32'h0);
    check("post_req_ready", 32'(req_ready[k]), 32'd1);
  endtask

  // Read with resp_ready held high: response at LATENCY, controller free again at LATENCY+1.
  task automatic b2b(input int k);
    int cyc, vcyc;
    wait_ready(k);
    resp_ready[k] = 1'b1;
    req_we = 1'b0; req_addr = 24'd4; req_valid[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    cyc = 0; vcyc = -1;
    while (!req_ready[k] && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (resp_valid[k]) vcyc = cyc;
    end
    resp_ready[k] = 1'b0;
    check("b2b_resp_cycle", 32'(vcyc), 32'(lat_of(k)));
    check("b2b_spacing", 32'(cyc), 32'(lat_of(k) + 1));
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = '0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata[0], 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd7);
    rst = 1'b0;

    // Basic write/read and partial strobes on every latency variant.
    for (int k = 0; k < 3; k++) begin
      txn(k, 1'b1, 24'd4, 32'hF0F0F0F0, 4'hF, 32'h0, 1'b0, 0);
      txn(k, 1'b0, 24'd4, 32'h0, 4'h0, 32'hF0F0F0F0, 1'b0, 0);
      txn(k, 1'b1, 24'd4, 32'h12345678, 4'b0011, 32'h0, 1'b0, 0);
      txn(k, 1'b0, 24'd4, 32'h0, 4'h0, 32'hF0F05678, 1'b0, 0);
      b2b(k);
    end

    // Out of range: no aliasing onto addr 300 mod 256 = 44.
    txn(0, 1'b1, 24'd44, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 0);
    txn(0, 1'b0, 24'd256, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    txn(0, 1'b1, 24'd300, 32'h11111111, 4'hF, 32'h0, 1'b1, 0);
    txn(0, 1'b0, 24'd44, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 0);
    txn(0, 1'b0, 24'hFFFF2C, 32'h0, 4'h0, 32'h0, 1'b1, 0);

    // Back-pressure with a competing write that must be ignored.
    txn(0, 1'b0, 24'd4, 32'h0, 4'h0, 32'hF0F05678, 1'b0, 3);
    txn(0, 1'b0, 24'd4, 32'h0, 4'h0, 32'hF0F05678, 1'b0, 0);

    // wstrb=0 write is a no-op that still responds.
    txn(0, 1'b1, 24'd4, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0);
    txn(0, 1'b0, 24'd4, 32'h0, 4'h0, 32'hF0F05678, 1'b0, 0);

    // Reset two cycles into a write: discarded, memory keeps the prior value.
    txn(0, 1'b1, 24'd8, 32'h55AA55AA, 4'hF, 32'h0, 1'b0, 0);
    req_we = 1'b1; req_addr = 24'd8; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", 32'(resp_valid[0]), 32'd0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready[0]), 32'd1);
    check("mid_rst_err", 32'(resp_err[0]), 32'd0);
    check("mid_rst_rdata", resp_rdata[0], 32'h0);
    repeat (6) begin
      @(posedge clk); #1;
      check("mid_rst_no_resp", 32'(resp_valid[0]), 32'd0);
    end
    txn(0, 1'b0, 24'd8, 32'h0, 4'h0, 32'h55AA55AA, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
